// File: rtl/lse_div.sv
// Two-stage pipelined log-domain divider: result = a - b with NEG_INF handling,
// saturation clamping and a saturating divide-by-zero event counter.
module lse_div #(
    parameter int WIDTH     = 24,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     operand_a,
    input  logic [WIDTH-1:0]     operand_b,
    input  logic [1:0]           pe_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 flag_dbz,
    output logic                 flag_sat,
    output logic                 flag_mode,
    output logic [CNT_WIDTH-1:0] dbz_count
);

    localparam logic [WIDTH-1:0] NEG_INF = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_FIN = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
    localparam logic signed [WIDTH:0] POS_LIM = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH:0] NEG_LIM = {2'b11, {(WIDTH-2){1'b0}}, 1'b1};

    logic                 s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]     s1_a_q, s1_a_d;
    logic [WIDTH-1:0]     s1_b_q, s1_b_d;
    logic [1:0]           s1_mode_q, s1_mode_d;
    logic                 s1_a_inf_q, s1_a_inf_d;
    logic                 s1_b_inf_q, s1_b_inf_d;

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 flag_dbz_q, flag_dbz_d;
    logic                 flag_sat_q, flag_sat_d;
    logic                 flag_mode_q, flag_mode_d;
    logic [CNT_WIDTH-1:0] dbz_count_q, dbz_count_d;

    logic                 s2_adv, s1_adv, in_fire, out_fire;
    logic signed [WIDTH:0] diff;
    logic [WIDTH-1:0]     calc_result;
    logic                 calc_dbz, calc_sat, calc_mode;

    // in_ready is combinational from out_ready so a full pipe drains and refills in one cycle.
    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = s2_adv;
    assign in_ready = !s1_valid_q || s1_adv;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_mode_d  = s1_mode_q;
        s1_a_inf_d = s1_a_inf_q;
        s1_b_inf_d = s1_b_inf_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_fire) begin
            s1_a_d     = operand_a;
            s1_b_d     = operand_b;
            s1_mode_d  = pe_mode;
            s1_a_inf_d = (operand_a == NEG_INF);
            s1_b_inf_d = (operand_b == NEG_INF);
        end
    end

    always_comb begin
        diff        = $signed({s1_a_q[WIDTH-1], s1_a_q}) - $signed({s1_b_q[WIDTH-1], s1_b_q});
        calc_result = diff[WIDTH-1:0];
        calc_dbz    = 1'b0;
        calc_sat    = 1'b0;
        calc_mode   = 1'b0;
        if (s1_mode_q != 2'b00) begin
            calc_result = NEG_INF;
            calc_mode   = 1'b1;
        end else if (s1_a_inf_q) begin
            calc_result = NEG_INF;
            calc_dbz    = s1_b_inf_q;
        end else if (s1_b_inf_q) begin
            calc_result = MAX_POS;
            calc_dbz    = 1'b1;
        end else if (diff > POS_LIM) begin
            calc_result = MAX_POS;
            calc_sat    = 1'b1;
        end else if (diff < NEG_LIM) begin
            // Clamp one above NEG_INF so a finite quotient never reads as log(0).
            calc_result = MIN_FIN;
            calc_sat    = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flag_dbz_d  = flag_dbz_q;
        flag_sat_d  = flag_sat_q;
        flag_mode_d = flag_mode_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d    = calc_result;
                flag_dbz_d  = calc_dbz;
                flag_sat_d  = calc_sat;
                flag_mode_d = calc_mode;
            end
        end
        dbz_count_d = dbz_count_q;
        if (out_fire && flag_dbz_q && (dbz_count_q != '1)) begin
            dbz_count_d = dbz_count_q + CNT_WIDTH'(1);
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flag_dbz_q  <= 1'b0;
            flag_sat_q  <= 1'b0;
            flag_mode_q <= 1'b0;
            dbz_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flag_dbz_q  <= flag_dbz_d;
            flag_sat_q  <= flag_sat_d;
            flag_mode_q <= flag_mode_d;
            dbz_count_q <= dbz_count_d;
        end
    end

    // NOTE: S1 payload is qualified by s1_valid_q, so it is left without reset.
    always_ff @(posedge clk) begin
        s1_a_q     <= s1_a_d;
        s1_b_q     <= s1_b_d;
        s1_mode_q  <= s1_mode_d;
        s1_a_inf_q <= s1_a_inf_d;
        s1_b_inf_q <= s1_b_inf_d;
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_dbz  = flag_dbz_q;
    assign flag_sat  = flag_sat_q;
    assign flag_mode = flag_mode_q;
    assign dbz_count = dbz_count_q;

endmodule

// File: tb/tb_lse_div.sv
// Bench for lse_div: directed steps plus random traffic, checked each cycle
// against a transaction-queue reference model of the divider.
module tb_lse_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] operand_a;
    logic [23:0] operand_b;
    logic [1:0]  pe_mode;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] result;
    logic        flag_dbz;
    logic        flag_sat;
    logic        flag_mode;
    logic [15:0] dbz_count;

    lse_div #(.WIDTH(24), .CNT_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .pe_mode   (pe_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_dbz  (flag_dbz),
        .flag_sat  (flag_sat),
        .flag_mode (flag_mode),
        .dbz_count (dbz_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic [1:0]  m;
        int          acc;
    } txn_t;

    txn_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   dbz_model = 0;
    int   ready_pat = 0;  // 0 always, 1 one-on/two-off, 2 never, 3 random
    logic accepted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected {result, dbz, sat, mode} from plain integer arithmetic.
    function automatic logic [26:0] model(input txn_t t);
        int d;
        d = int'($signed(t.a)) - int'($signed(t.b));
        if (t.m != 2'b00)              return {24'h800000, 3'b001};
        if (t.a == 24'h800000)         return {24'h800000, (t.b == 24'h800000), 2'b00};
        if (t.b == 24'h800000)         return {24'h7FFFFF, 3'b100};
        if (d > 8388607)               return {24'h7FFFFF, 3'b010};
        if (d < -8388607)              return {24'h800001, 3'b010};
        return {24'(d), 3'b000};
    endfunction

    task automatic cycle(input logic iv, input logic [23:0] a, input logic [23:0] b,
                         input logic [1:0] m);
        logic   ordy, exp_rdy, exp_ov;
        logic [26:0] exp_res;
        txn_t   t;
        case (ready_pat)
            0:       ordy = 1'b1;
            1:       ordy = (cyc % 3 == 0);
            2:       ordy = 1'b0;
            default: ordy = 1'($urandom_range(0, 1));
        endcase
        in_valid = iv; operand_a = a; operand_b = b; pe_mode = m; out_ready = ordy;
        #1;
        exp_rdy = !(q.size() == 2 && !ordy);
        exp_ov  = (q.size() > 0) && (cyc - q[0].acc >= 2);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        check("dbz_count", 32'(dbz_count), 32'(dbz_model));
        if (exp_ov) begin
            exp_res = model(q[0]);
            check("result_flags", 32'({result, flag_dbz, flag_sat, flag_mode}), 32'(exp_res));
            if (ordy) begin
                if (exp_res[2] && dbz_model < 65535) dbz_model++;
                void'(q.pop_front());
            end
        end
        accepted = iv && exp_rdy;
        if (accepted) begin
            t.a = a; t.b = b; t.m = m; t.acc = cyc;
            q.push_back(t);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [23:0] a, input logic [23:0] b, input logic [1:0] m);
        int n = 0;
        do begin
            cycle(1'b1, a, b, m);
            n++;
        end while (!accepted && n < 50);
        check("send_accepted", 32'(accepted), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 200) begin
            cycle(1'b0, 24'h0, 24'h0, 2'b00);
            n++;
        end
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    function automatic logic [23:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 24'h800000;
            1:       return 24'h7FFFFF;
            2:       return 24'h800001;
            default: return 24'($urandom);
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; operand_a = '0; operand_b = '0;
        pe_mode = 2'b00; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result_flags", 32'({result, flag_dbz, flag_sat, flag_mode}), 32'd0);
        check("rst_dbz_count", 32'(dbz_count), 32'd0);
        rst_n = 1'b1;

        // Basic divides
        ready_pat = 0;
        send(24'h300000, 24'h100000, 2'b00);
        send(24'h080000, 24'h030000, 2'b00);
        send(24'h123456, 24'h000000, 2'b00);
        send(24'h000000, 24'h123456, 2'b00);
        drain();

        // Special values
        send(24'h800000, 24'h123456, 2'b00);
        send(24'h123456, 24'h800000, 2'b00);
        send(24'h800000, 24'h800000, 2'b00);
        drain();
        check("dbz_count_two", 32'(dbz_count), 32'd2);

        // Saturation boundaries
        send(24'h7FFFFF, 24'hFFFFFF, 2'b00);
        send(24'h800001, 24'h000001, 2'b00);
        send(24'h000001, 24'h7FFFFF, 2'b00);
        drain();

        // Backpressure: 8 pairs against a 1-on/2-off sink
        ready_pat = 1;
        for (int i = 0; i < 8; i++) send(24'h010000 * i, 24'h001000 + 24'(i), 2'b00);
        drain();

        // Unsupported mode
        ready_pat = 0;
        send(24'h100000, 24'h100000, 2'b01);
        drain();

        // Reset with two divide-by-zero transfers in flight
        ready_pat = 2;
        send(24'h111111, 24'h800000, 2'b00);
        send(24'h222222, 24'h800000, 2'b00);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        q.delete();
        dbz_model = 0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_dbz_count", 32'(dbz_count), 32'd0);
        ready_pat = 0;
        repeat (5) cycle(1'b0, 24'h0, 24'h0, 2'b00);

        // Random traffic with random backpressure
        ready_pat = 3;
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), rand_op(), rand_op(),
                  ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
        end
        ready_pat = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
